// File: rtl/alarme_ctrl_if.sv
// Bundle of the keypad/time inputs and display/buzzer outputs of alarme_ctrl.
// The master side (keypad decoder + time base) drives keys and time; the
// slave side (alarme_ctrl) drives the edit buffer, armed flags and buzzer.
interface alarme_ctrl_if #(
  parameter int NUM_SLOTS = 4
);
  logic                 key_valid;
  logic [3:0]           key_code;
  logic                 tick_1hz;
  logic [23:0]          cur_time;
  logic [23:0]          edit_digits;
  logic                 editing;
  logic [2:0]           edit_pos;
  logic [1:0]           edit_slot;
  logic [NUM_SLOTS-1:0] alarm_armed;
  logic                 buzzer;
  logic [1:0]           ringing_slot;

  modport master (
    output key_valid, key_code, tick_1hz, cur_time,
    input  edit_digits, editing, edit_pos, edit_slot, alarm_armed, buzzer, ringing_slot
  );

  modport slave (
    input  key_valid, key_code, tick_1hz, cur_time,
    output edit_digits, editing, edit_pos, edit_slot, alarm_armed, buzzer, ringing_slot
  );
endinterface

// File: rtl/alarme_ctrl.sv
// Alarm controller: a keypad entry FSM edits a 6-digit BCD buffer and stores
// it into one of NUM_SLOTS alarm registers; a ring FSM compares armed slots
// with the running clock on each 1 Hz tick and drives the buzzer.
// Optional macro ALARME_SNOOZE_EN adds a SNOOZE state to the ring FSM.
module alarme_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int BUZZ_TICKS   = 60,
  parameter int SNOOZE_TICKS = 300
) (
  input logic          clk,
  input logic          rst,
  alarme_ctrl_if.slave bus
);
  // Counter is sized to hold whichever reload value is larger.
  localparam int CNT_MAX = (SNOOZE_TICKS > BUZZ_TICKS) ? SNOOZE_TICKS : BUZZ_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {E_IDLE, E_SLOT, E_DIGIT, E_CONFIRM} entry_t;
`ifdef ALARME_SNOOZE_EN
  typedef enum logic [1:0] {R_QUIET, R_RING, R_SNOOZE} ring_t;
`else
  typedef enum logic [1:0] {R_QUIET, R_RING} ring_t;
`endif

  entry_t               entry_q, entry_d;
  ring_t                ring_q, ring_d;
  logic [1:0]           slot_q, slot_d;
  logic [2:0]           pos_q, pos_d;
  logic [23:0]          digits_q, digits_d;
  logic [1:0]           ring_slot_q, ring_slot_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [23:0]          alarm_time_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] armed_q;
  logic [NUM_SLOTS-1:0] hit;
  logic                 wr_en, disarm_en;
  logic                 match_any;
  logic [1:0]           match_idx;
  logic [3:0]           digit_lim;

  wire key_cancel = bus.key_valid && (bus.key_code == 4'd10);
  wire key_next   = bus.key_valid && (bus.key_code == 4'd11);
  wire key_set    = bus.key_valid && (bus.key_code == 4'd12);
  wire key_digit  = bus.key_valid && (bus.key_code <= 4'd9);

  // Per-slot storage and match detection; the match sees pre-write contents.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        alarm_time_q[gi] <= '0;
        armed_q[gi]      <= 1'b0;
      end else if (wr_en && (slot_q == 2'(gi))) begin
        alarm_time_q[gi] <= digits_q;
        armed_q[gi]      <= 1'b1;
      end else if (disarm_en && (slot_q == 2'(gi))) begin
        armed_q[gi]      <= 1'b0;
      end
    end
    assign hit[gi] = armed_q[gi] && (alarm_time_q[gi] == bus.cur_time);
  end

  // Lowest-index armed slot that matches wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_any = 1'b1;
        match_idx = 2'(i);
      end
    end
  end

  // Highest digit accepted at the current edit position (24h clock, BCD).
  always_comb begin
    digit_lim = 4'd9;
    case (pos_q)
      3'd0:    digit_lim = 4'd2;
      3'd1:    digit_lim = (digits_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2:    digit_lim = 4'd5;
      3'd4:    digit_lim = 4'd5;
      default: digit_lim = 4'd9;
    endcase
  end

  // Entry FSM next state: slot select, digit editing and confirm.
  always_comb begin
    entry_d   = entry_q;
    slot_d    = slot_q;
    pos_d     = pos_q;
    digits_d  = digits_q;
    wr_en     = 1'b0;
    disarm_en = 1'b0;
    case (entry_q)
      E_IDLE: begin
        if (key_set) entry_d = E_SLOT;
      end
      E_SLOT: begin
        if (key_next) begin
          slot_d = (slot_q == 2'(NUM_SLOTS - 1)) ? 2'd0 : slot_q + 2'd1;
        end else if (key_set) begin
          entry_d  = E_DIGIT;
          pos_d    = 3'd0;
          digits_d = alarm_time_q[slot_q];
        end else if (key_cancel) begin
          entry_d = E_IDLE;
        end
      end
      E_DIGIT: begin
        if ((key_digit && (bus.key_code <= digit_lim)) || key_next) begin
          if (key_digit) begin
            for (int p = 0; p < 6; p++) begin
              if (pos_q == 3'(p)) digits_d[23-4*p -: 4] = bus.key_code;
            end
            // Hour 2x only allows x <= 3; clamp a stale H0.
            if ((pos_q == 3'd0) && (bus.key_code == 4'd2) && (digits_q[19:16] > 4'd3))
              digits_d[19:16] = 4'd3;
          end
          if (pos_q == 3'd5) entry_d = E_CONFIRM;
          else               pos_d   = pos_q + 3'd1;
        end else if (key_cancel) begin
          entry_d = E_IDLE;
        end
      end
      E_CONFIRM: begin
        if (key_next) begin
          wr_en   = 1'b1;
          entry_d = E_IDLE;
        end else if (key_cancel) begin
          disarm_en = 1'b1;
          entry_d   = E_IDLE;
        end
      end
      default: entry_d = E_IDLE;
    endcase
    // Stopping a ring also abandons any entry without touching the slots.
    if ((ring_q == R_RING) && key_cancel) begin
      entry_d   = E_IDLE;
      wr_en     = 1'b0;
      disarm_en = 1'b0;
    end
  end

  // Ring FSM next state: trigger on tick, count down, stop on cancel.
  always_comb begin
    ring_d      = ring_q;
    ring_slot_d = ring_slot_q;
    cnt_d       = cnt_q;
    case (ring_q)
      R_QUIET: begin
        if (bus.tick_1hz && match_any) begin
          ring_d      = R_RING;
          ring_slot_d = match_idx;
          cnt_d       = CNT_W'(BUZZ_TICKS);
        end
      end
      R_RING: begin
        if (key_cancel) begin
          ring_d = R_QUIET;
`ifdef ALARME_SNOOZE_EN
        end else if (key_next) begin
          ring_d = R_SNOOZE;
          cnt_d  = CNT_W'(SNOOZE_TICKS);
`endif
        end else if (bus.tick_1hz) begin
          if (cnt_q <= CNT_W'(1)) begin
            ring_d = R_QUIET;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
`ifdef ALARME_SNOOZE_EN
      R_SNOOZE: begin
        if (key_cancel || (disarm_en && (slot_q == ring_slot_q))) begin
          ring_d = R_QUIET;
        end else if (bus.tick_1hz) begin
          if (cnt_q <= CNT_W'(1)) begin
            ring_d = R_RING;
            cnt_d  = CNT_W'(BUZZ_TICKS);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
`endif
      default: ring_d = R_QUIET;
    endcase
  end

  // State and edit-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q     <= E_IDLE;
      ring_q      <= R_QUIET;
      slot_q      <= 2'd0;
      pos_q       <= 3'd0;
      digits_q    <= 24'd0;
      ring_slot_q <= 2'd0;
      cnt_q       <= '0;
    end else begin
      entry_q     <= entry_d;
      ring_q      <= ring_d;
      slot_q      <= slot_d;
      pos_q       <= pos_d;
      digits_q    <= digits_d;
      ring_slot_q <= ring_slot_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.edit_digits  = digits_q;
  assign bus.editing      = (entry_q != E_IDLE);
  assign bus.edit_pos     = pos_q;
  assign bus.edit_slot    = slot_q;
  assign bus.alarm_armed  = armed_q;
  assign bus.buzzer       = (ring_q == R_RING);
  assign bus.ringing_slot = ring_slot_q;
endmodule

// File: tb/tb_alarme_ctrl.sv
// Directed bench for alarme_ctrl: expectations are queued before each
// stimulus step and compared once the DUT has registered its response.
module tb_alarme_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alarme_ctrl_if #(.NUM_SLOTS(4)) bus ();

  alarme_ctrl #(.NUM_SLOTS(4), .BUZZ_TICKS(60), .SNOOZE_TICKS(300)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam int S_DIG = 0, S_EDT = 1, S_POS = 2, S_SLT = 3, S_ARM = 4, S_BUZ = 5, S_RSL = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [23:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [23:0] obs(input int sel);
    case (sel)
      S_DIG:   return bus.edit_digits;
      S_EDT:   return {23'd0, bus.editing};
      S_POS:   return {21'd0, bus.edit_pos};
      S_SLT:   return {22'd0, bus.edit_slot};
      S_ARM:   return {20'd0, bus.alarm_armed};
      S_BUZ:   return {23'd0, bus.buzzer};
      default: return {22'd0, bus.ringing_slot};
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [23:0] o;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      $display("check %s: observed %h expected %h", e.tag, o, e.val);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    drain();
  endtask

  task automatic tick();
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    drain();
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.tick_1hz  = 1'b0;
    bus.cur_time  = 24'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    expect_v("rst_editing", S_EDT, 24'd0);
    expect_v("rst_buzzer", S_BUZ, 24'd0);
    expect_v("rst_armed", S_ARM, 24'd0);
    expect_v("rst_digits", S_DIG, 24'd0);
    expect_v("rst_pos", S_POS, 24'd0);
    expect_v("rst_slot", S_SLT, 24'd0);
    expect_v("rst_ring_slot", S_RSL, 24'd0);
    drain();
    rst = 1'b0;

    // Entry accept: slot 0 = 07:30:00
    expect_v("set_to_slot", S_EDT, 24'd1);
    press(4'd12);
    expect_v("digit_pos0", S_POS, 24'd0);
    expect_v("digit_load0", S_DIG, 24'h000000);
    press(4'd12);
    press(4'd0);
    expect_v("enter_7", S_DIG, 24'h070000);
    expect_v("pos_after_7", S_POS, 24'd2);
    press(4'd7);
    press(4'd3);
    press(4'd0);
    press(4'd0);
    expect_v("confirm_digits", S_DIG, 24'h073000);
    expect_v("confirm_pos", S_POS, 24'd5);
    press(4'd0);
    expect_v("store_editing", S_EDT, 24'd0);
    expect_v("store_armed", S_ARM, 24'b0001);
    press(4'd11);

    // Stored value reloads; p0 limit
    press(4'd12);
    expect_v("reload_0730", S_DIG, 24'h073000);
    expect_v("reload_pos", S_POS, 24'd0);
    press(4'd12);
    expect_v("drop3_pos", S_POS, 24'd0);
    expect_v("drop3_digits", S_DIG, 24'h073000);
    press(4'd3);
    // Store 08:30:00 to get H0 = 8
    press(4'd0);
    expect_v("enter_8", S_DIG, 24'h083000);
    press(4'd8);
    press(4'd11);
    press(4'd11);
    press(4'd11);
    press(4'd11);
    expect_v("store_0830_armed", S_ARM, 24'b0001);
    press(4'd11);
    press(4'd12);
    expect_v("reload_0830", S_DIG, 24'h083000);
    press(4'd12);
    expect_v("h0_forced", S_DIG, 24'h233000);
    expect_v("h0_forced_pos", S_POS, 24'd1);
    press(4'd2);
    expect_v("drop4_p1_pos", S_POS, 24'd1);
    expect_v("drop4_p1_dig", S_DIG, 24'h233000);
    press(4'd4);
    press(4'd11);
    expect_v("drop6_p2_pos", S_POS, 24'd2);
    expect_v("drop6_p2_dig", S_DIG, 24'h233000);
    press(4'd6);
    expect_v("abort_editing", S_EDT, 24'd0);
    expect_v("abort_armed", S_ARM, 24'b0001);
    press(4'd10);

    // Arm slots 1 and 2 at 12:00:05
    press(4'd12);
    expect_v("slot_next1", S_SLT, 24'd1);
    press(4'd11);
    press(4'd12);
    press(4'd1); press(4'd2); press(4'd0); press(4'd0); press(4'd0); press(4'd5);
    expect_v("arm_slot1", S_ARM, 24'b0011);
    press(4'd11);
    press(4'd12);
    expect_v("slot_next2", S_SLT, 24'd2);
    press(4'd11);
    press(4'd12);
    press(4'd1); press(4'd2); press(4'd0); press(4'd0); press(4'd0); press(4'd5);
    expect_v("arm_slot2", S_ARM, 24'b0111);
    press(4'd11);

    // Match: lowest slot wins, rings for 60 ticks
    bus.cur_time = 24'h120005;
    expect_v("ring_start", S_BUZ, 24'd1);
    expect_v("ring_slot_low", S_RSL, 24'd1);
    tick();
    bus.cur_time = 24'h120006;
    for (int i = 0; i < 58; i++) tick();
    expect_v("ring_tick59", S_BUZ, 24'd1);
    tick();
    expect_v("ring_tick60_off", S_BUZ, 24'd0);
    tick();

    // Stop during ring while editing
    press(4'd12);
    press(4'd12);
    expect_v("edit_during_pos", S_POS, 24'd1);
    press(4'd1);
    bus.cur_time = 24'h120005;
    expect_v("ring2_start", S_BUZ, 24'd1);
    expect_v("ring2_editing", S_EDT, 24'd1);
    tick();
    bus.cur_time = 24'h000001;
    expect_v("stop_buzzer", S_BUZ, 24'd0);
    expect_v("stop_editing", S_EDT, 24'd0);
    expect_v("stop_armed", S_ARM, 24'b0111);
    press(4'd10);
    press(4'd12);
    expect_v("slot2_unchanged", S_DIG, 24'h120005);
    press(4'd12);
    press(4'd10);

    // Slot wrap and disarm
    press(4'd12);
    expect_v("slot_to3", S_SLT, 24'd3);
    press(4'd11);
    expect_v("slot_wrap0", S_SLT, 24'd0);
    press(4'd11);
    expect_v("wrap_load", S_DIG, 24'h083000);
    press(4'd12);
    press(4'd11); press(4'd11); press(4'd11); press(4'd11); press(4'd11);
    expect_v("walk_pos5", S_POS, 24'd5);
    press(4'd11);
    expect_v("disarm_armed", S_ARM, 24'b0110);
    expect_v("disarm_editing", S_EDT, 24'd0);
    press(4'd10);
    bus.cur_time = 24'h083000;
    expect_v("disarmed_no_ring", S_BUZ, 24'd0);
    tick();

    // Ring again, then key 11
    bus.cur_time = 24'h120005;
    expect_v("ring3_start", S_BUZ, 24'd1);
    tick();
    bus.cur_time = 24'h000002;
`ifdef ALARME_SNOOZE_EN
    expect_v("snooze_silent", S_BUZ, 24'd0);
    press(4'd11);
    for (int i = 0; i < 298; i++) tick();
    expect_v("snooze_tick299", S_BUZ, 24'd0);
    tick();
    expect_v("snooze_rering", S_BUZ, 24'd1);
    expect_v("snooze_rering_slot", S_RSL, 24'd1);
    tick();
`else
    expect_v("next_no_effect", S_BUZ, 24'd1);
    press(4'd11);
`endif

    // Asynchronous reset while ringing
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_v("async_rst_buzzer", S_BUZ, 24'd0);
    expect_v("async_rst_armed", S_ARM, 24'd0);
    expect_v("async_rst_editing", S_EDT, 24'd0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    bus.cur_time = 24'h120005;
    expect_v("post_rst_no_ring", S_BUZ, 24'd0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
